// File: rtl/cache_2way_if.sv
// Bus bundle for the 2-way read cache: CPU data-port side, SRAM-controller side and
// hit/miss statistics. The cache uses the slave view and its environment uses the master view.
interface cache_2way_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int LINE_W = 64
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, mem_rd, mem_wr, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, mem_rd, mem_wr, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_2way_ctrl.sv
// 2-way set-associative write-through read cache with LRU replacement and a line-fill FSM,
// placed between the MEM-stage data port and the SRAM controller.
module cache_2way_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 1,
    parameter int DATA_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    cache_2way_if.slave bus
);
    localparam int SETS       = 1 << INDEX_W;
    localparam int LINE_WORDS = 1 << OFFSET_W;
    localparam int LINE_W     = DATA_W * LINE_WORDS;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [SETS-1:0]    valid0_r;
    logic [SETS-1:0]    valid1_r;
    logic [SETS-1:0]    lru_r;
    logic [TAG_W-1:0]   tag0_r  [SETS];
    logic [TAG_W-1:0]   tag1_r  [SETS];
    logic [LINE_W-1:0]  data0_r [SETS];
    logic [LINE_W-1:0]  data1_r [SETS];
    logic [31:0]        hit_cnt_r;
    logic [31:0]        miss_cnt_r;

    logic [TAG_W-1:0]    tag_s;
    logic [INDEX_W-1:0]  idx_s;
    logic [OFFSET_W-1:0] off_s;
    logic                hit0_s;
    logic                hit1_s;
    logic                victim_s;
    logic [LINE_W-1:0]   line_s;
    logic                rd_hit_s;
    logic                rd_miss_s;
    logic                wr_hit_s;
    logic                fill_s;
    logic                cpu_ready_s;
    logic [DATA_W-1:0]   cpu_rdata_s;
    logic                mem_rd_s;
    logic                mem_wr_s;
    logic [ADDR_W-1:0]   mem_addr_s;

    assign tag_s  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign idx_s  = bus.cpu_addr[OFFSET_W +: INDEX_W];
    assign off_s  = bus.cpu_addr[OFFSET_W-1:0];
    assign hit0_s = valid0_r[idx_s] & (tag0_r[idx_s] == tag_s);
    assign hit1_s = valid1_r[idx_s] & (tag1_r[idx_s] == tag_s);
    assign line_s = hit1_s ? data1_r[idx_s] : data0_r[idx_s];

    // Fill an empty way first (way0 before way1); only a full set consults the LRU bit.
    assign victim_s = !valid0_r[idx_s] ? 1'b0 :
                      !valid1_r[idx_s] ? 1'b1 : lru_r[idx_s];

    // Next-state and output decode; memory strobes depend on the state register only.
    always_comb begin
        state_s     = state_r;
        rd_hit_s    = 1'b0;
        rd_miss_s   = 1'b0;
        wr_hit_s    = 1'b0;
        fill_s      = 1'b0;
        cpu_ready_s = 1'b0;
        cpu_rdata_s = {DATA_W{1'b0}};
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (bus.cpu_rd) begin
                    if (hit0_s | hit1_s) begin
                        rd_hit_s    = 1'b1;
                        cpu_ready_s = 1'b1;
                        cpu_rdata_s = line_s[off_s*DATA_W +: DATA_W];
                    end else begin
                        rd_miss_s = 1'b1;
                        state_s   = ST_FILL;
                    end
                end else if (bus.cpu_wr) begin
                    wr_hit_s = hit0_s | hit1_s;
                    state_s  = ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                mem_rd_s   = 1'b1;
                mem_addr_s = {tag_s, idx_s, {OFFSET_W{1'b0}}};
                if (bus.mem_ready) begin
                    fill_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                mem_wr_s   = 1'b1;
                mem_addr_s = bus.cpu_addr;
                if (bus.mem_ready) begin
                    cpu_ready_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Valid bits, LRU bits and statistics; LRU always points away from the way just used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_r   <= {SETS{1'b0}};
            valid1_r   <= {SETS{1'b0}};
            lru_r      <= {SETS{1'b0}};
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (rd_hit_s) begin
                hit_cnt_r    <= hit_cnt_r + 32'd1;
                lru_r[idx_s] <= hit0_s;
            end
            if (rd_miss_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
            if (wr_hit_s) begin
                lru_r[idx_s] <= hit0_s;
            end
            if (fill_s) begin
                if (victim_s) begin
                    valid1_r[idx_s] <= 1'b1;
                end else begin
                    valid0_r[idx_s] <= 1'b1;
                end
                lru_r[idx_s] <= ~victim_s;
            end
        end
    end

    // Tag and line storage: whole-line write on fill, single-word update on a write hit.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            if (victim_s) begin
                tag1_r[idx_s]  <= tag_s;
                data1_r[idx_s] <= bus.mem_rdata;
            end else begin
                tag0_r[idx_s]  <= tag_s;
                data0_r[idx_s] <= bus.mem_rdata;
            end
        end else if (wr_hit_s) begin
            if (hit1_s) begin
                data1_r[idx_s][off_s*DATA_W +: DATA_W] <= bus.cpu_wdata;
            end else begin
                data0_r[idx_s][off_s*DATA_W +: DATA_W] <= bus.cpu_wdata;
            end
        end
    end

    assign bus.cpu_ready = cpu_ready_s;
    assign bus.cpu_rdata = cpu_rdata_s;
    assign bus.mem_rd    = mem_rd_s;
    assign bus.mem_wr    = mem_wr_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = bus.cpu_wdata;
    assign bus.hit_cnt   = hit_cnt_r;
    assign bus.miss_cnt  = miss_cnt_r;

endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Scoreboard bench for cache_2way_ctrl: a recency-list model of each set predicts hit/miss,
// a backing-store array predicts data, and a monitor checks every completed request.
module tb_cache_2way_ctrl;
    localparam int SETS = 64;

    typedef struct {
        logic        is_rd;
        logic [31:0] rdata;
        logic        fill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_2way_if bus ();
    cache_2way_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [logic [17:0]];
    bit          auto_resp = 1'b0;
    bit          saw_fill  = 1'b0;
    logic [17:0] cur_addr  = 18'd0;
    logic [31:0] cur_wdata = 32'd0;

    // Reference model: per set a most-recent-first list of at most two cached tags.
    logic [10:0] m_tag [SETS][2];
    int          m_cnt [SETS];
    logic [31:0] m_hit;
    logic [31:0] m_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] memw(input logic [17:0] a);
        if (mem.exists(a)) return mem[a];
        return ({14'd0, a} * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
        m_hit  = 32'd0;
        m_miss = 32'd0;
    endfunction

    // Returns 1 when the access must fetch a line from memory.
    function automatic bit model_access(input bit wr, input logic [17:0] a);
        int          s;
        int          pos;
        logic [10:0] t;
        s   = int'(a[6:1]);
        t   = a[17:7];
        pos = -1;
        for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
        if (pos >= 0) begin
            if (!wr) m_hit++;
            if (pos == 1) begin
                m_tag[s][1] = m_tag[s][0];
                m_tag[s][0] = t;
            end
            return 1'b0;
        end
        if (wr) return 1'b0;
        m_miss++;
        m_hit++;
        m_tag[s][1] = m_tag[s][0];
        m_tag[s][0] = t;
        if (m_cnt[s] < 2) m_cnt[s]++;
        return 1'b1;
    endfunction

    task automatic do_req(input bit wr, input logic [17:0] a, input logic [31:0] d);
        exp_t e;
        bit   got;
        got     = 1'b0;
        e.is_rd = !wr;
        e.fill  = model_access(wr, a);
        e.rdata = wr ? 32'd0 : memw(a);
        exp_q.push_back(e);
        @(posedge clk); #1;
        cur_addr      = a;
        cur_wdata     = d;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_rd    = !wr;
        bus.cpu_wr    = wr;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.cpu_ready;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_timeout: got no cpu_ready expected cpu_ready for addr %h", a);
            exp_q.delete();
        end
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        check("hit_cnt", bus.hit_cnt, m_hit);
        check("miss_cnt", bus.miss_cnt, m_miss);
    endtask

    // Monitor: pops one expectation per completed request; also polices idle outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_rd) saw_fill = 1'b1;
            if (bus.mem_rd && bus.mem_wr) check("mem_rd_wr_excl", 32'd1, 32'd0);
            if ((bus.cpu_rd || bus.cpu_wr) && !bus.cpu_ready)
                check("rdata_idle_zero", bus.cpu_rdata, 32'd0);
            if (bus.cpu_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {31'd0, bus.cpu_ready}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_rd ? "rd_data" : "wr_rdata_zero", bus.cpu_rdata, e.rdata);
                    check("fill_seen", {31'd0, saw_fill}, {31'd0, e.fill});
                    saw_fill = 1'b0;
                end
            end
        end
    end

    // SRAM controller model with random latency and a backing store.
    initial begin
        int lat;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 64'd0;
        forever begin
            if (auto_resp && (bus.mem_rd || bus.mem_wr)) begin
                lat = $urandom_range(0, 3);
                repeat (lat) begin
                    @(posedge clk); #1;
                end
                if (bus.mem_wr) begin
                    check("mem_wr_addr", {14'd0, bus.mem_addr}, {14'd0, cur_addr});
                    check("mem_wdata", bus.mem_wdata, cur_wdata);
                    mem[cur_addr] = cur_wdata;
                end else begin
                    check("mem_rd_addr", {14'd0, bus.mem_addr}, {14'd0, cur_addr[17:1], 1'b0});
                    bus.mem_rdata = {memw({cur_addr[17:1], 1'b1}), memw({cur_addr[17:1], 1'b0})};
                end
                bus.mem_ready = 1'b1;
                @(posedge clk); #1;
                bus.mem_ready = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no end of test expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [17:0] a;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 18'd0;
        bus.cpu_wdata = 32'd0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_hit_cnt", bus.hit_cnt, 32'd0);
        check("rst_miss_cnt", bus.miss_cnt, 32'd0);
        rst_n     = 1'b1;
        auto_resp = 1'b1;

        // Miss then fill, then a hit on the other word of the same line.
        mem[18'h00004] = 32'hAAAA_AAAA;
        mem[18'h00005] = 32'hBBBB_BBBB;
        do_req(1'b0, 18'h00004, 32'd0);
        do_req(1'b0, 18'h00005, 32'd0);

        // Conflicts at index 2 between tags 0, 1 and 2.
        do_req(1'b0, 18'h00004, 32'd0);
        do_req(1'b0, 18'h00084, 32'd0);
        do_req(1'b0, 18'h00004, 32'd0);
        do_req(1'b0, 18'h00104, 32'd0);
        do_req(1'b0, 18'h00004, 32'd0);
        do_req(1'b0, 18'h00084, 32'd0);

        // Write hit updates the cached word; write miss does not allocate.
        do_req(1'b0, 18'h00004, 32'd0);
        do_req(1'b1, 18'h00004, 32'h1234_5678);
        do_req(1'b0, 18'h00004, 32'd0);
        do_req(1'b1, {11'd5, 6'd9, 1'b1}, 32'hDEAD_BEEF);
        do_req(1'b0, {11'd5, 6'd9, 1'b1}, 32'd0);

        // Randomized mix over a small tag/index space to force reuse and eviction.
        for (int n = 0; n < 300; n++) begin
            a = {11'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            do_req(($urandom_range(0, 9) < 3), a, $urandom);
        end

        // Reset in the middle of a fill; a late mem_ready must be ignored.
        auto_resp = 1'b0;
        @(posedge clk); #1;
        bus.cpu_addr = {11'd7, 6'd3, 1'b0};
        bus.cpu_rd   = 1'b1;
        @(posedge clk); #1;
        check("fill_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_drops_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        bus.cpu_rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.mem_rdata = 64'h5555_5555_6666_6666;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("late_ready_no_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("late_ready_no_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("post_rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        check("post_rst_hit_cnt", bus.hit_cnt, 32'd0);
        check("post_rst_miss_cnt", bus.miss_cnt, 32'd0);
        model_reset();
        exp_q.delete();
        saw_fill  = 1'b0;
        auto_resp = 1'b1;
        do_req(1'b0, 18'h00004, 32'd0);

        // Miss counter wrap.
        @(posedge clk); #1;
        force dut.miss_cnt_r = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.miss_cnt_r;
        m_miss = 32'hFFFF_FFFF;
        do_req(1'b0, {11'h7FF, 6'd63, 1'b1}, 32'd0);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
